qoi_stream_arbiter: RTL and testbench

//   Shares one qoi_decompressor between N_SRC compressed-QOI AXI-stream sources. Arbitration is per frame
//   (one whole .qoi file), round-robin. The block sits between the sources and decompressor i_*.
//   It records the source ID of every frame it admits, so downstream logic can tag the decompressor's pixel output.

---
 rtl/qoi_pkg.sv | 12 +
 rtl/qoi_tag_fifo.sv | 57 +++++
 rtl/qoi_stream_arbiter.sv | 109 ++++++++++
 tb/tb_qoi_stream_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qoi_pkg.sv
// Shared constants and helpers for the QOI stream front-end.
// Imported by the tag FIFO and the stream arbiter.
package qoi_pkg;

    localparam int QOI_WORD_W = 32;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/qoi_tag_fifo.sv
// Synchronous FIFO holding the source ID of each frame admitted to the decompressor.
// The head is read from registered storage, so an entry appears the cycle after its push.
module qoi_tag_fifo
    import qoi_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/qoi_stream_arbiter.sv
// Per-frame round-robin arbiter sharing one QOI decompressor among N_SRC word streams,
// recording the source ID of every admitted frame so the pixel output can be tagged.
module qoi_stream_arbiter
    import qoi_pkg::*;
#(
    parameter  int N_SRC     = 4,
    parameter  int TAG_DEPTH = 4,
    localparam int SRC_W     = clog2_min1(N_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC-1:0]              s_tvalid,
    output logic [N_SRC-1:0]              s_tready,
    input  logic [N_SRC-1:0]              s_tlast,
    input  logic [N_SRC*QOI_WORD_W-1:0]   s_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [QOI_WORD_W-1:0]         m_tdata,
    input  logic                          pix_tvalid,
    input  logic                          pix_tready,
    input  logic                          pix_tlast,
    output logic [SRC_W-1:0]              out_src,
    output logic                          out_src_vld,
    output logic                          busy,
    output logic                          err_orphan
);

    localparam logic [0:0]       ST_ARB   = 1'b0;
    localparam logic [0:0]       ST_PASS  = 1'b1;
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRC - 1);

    logic [0:0]       lock;
    logic [SRC_W-1:0] gnt;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] pick;
    logic             pick_vld;
    logic             grant;
    logic             tag_full;
    logic             tag_empty;
    logic             pix_eof;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin : rr_pick
        logic [SRC_W-1:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = rr_ptr;
        for (int i = 0; i < N_SRC; i++) begin
            idx = (idx == LAST_SRC) ? '0 : idx + 1'b1;
            if (!pick_vld && s_tvalid[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign grant   = (lock == ST_ARB) && pick_vld && !tag_full;
    assign pix_eof = pix_tvalid && pix_tready && pix_tlast;

    always_comb begin : pass_mux
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        s_tready = '0;
        if (lock == ST_PASS) begin
            m_tvalid      = s_tvalid[gnt];
            m_tlast       = s_tlast[gnt];
            m_tdata       = s_tdata[int'(gnt)*QOI_WORD_W +: QOI_WORD_W];
            s_tready[gnt] = m_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock       <= ST_ARB;
            gnt        <= '0;
            rr_ptr     <= LAST_SRC;
            err_orphan <= 1'b0;
        end else begin
            if (grant) begin
                lock   <= ST_PASS;
                gnt    <= pick;
                rr_ptr <= pick;
            end else if ((lock == ST_PASS) && m_tvalid && m_tready && m_tlast) begin
                lock <= ST_ARB;
            end
            if (pix_eof && tag_empty) err_orphan <= 1'b1;
        end
    end

    qoi_tag_fifo #(
        .WIDTH (SRC_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (pick),
        .pop       (pix_eof),
        .full      (tag_full),
        .empty     (tag_empty),
        .head      (out_src)
    );

    assign out_src_vld = !tag_empty;
    assign busy        = lock;

endmodule

// File: tb/tb_qoi_stream_arbiter.sv
// Scoreboard bench for qoi_stream_arbiter: a round-robin frame model fills expected queues
// at load time and a negedge monitor compares whatever the DUT presents.
module tb_qoi_stream_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int SW    = 2;

    typedef struct {
        int          src;
        logic [31:0] data;
        logic        last;
        logic        first;
    } item_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast;
    logic [N*32-1:0] s_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [31:0]     m_tdata;
    logic            pix_tvalid;
    logic            pix_tready;
    logic            pix_tlast;
    logic [SW-1:0]   out_src;
    logic            out_src_vld;
    logic            busy;
    logic            err_orphan;

    qoi_stream_arbiter #(
        .N_SRC     (N),
        .TAG_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .s_tdata     (s_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_tdata     (m_tdata),
        .pix_tvalid  (pix_tvalid),
        .pix_tready  (pix_tready),
        .pix_tlast   (pix_tlast),
        .out_src     (out_src),
        .out_src_vld (out_src_vld),
        .busy        (busy),
        .err_orphan  (err_orphan)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    item_t        src_q [N][$];
    item_t        stage [N][$];
    item_t        exp_q [$];
    int           tag_q [$];
    logic [N-1:0] en;
    logic [N-1:0] hs;
    int rr_last;
    int mt_mode;
    int auto_pop;
    int gap_chk;
    int gap_armed;
    int frames_done;
    int pops_done;
    int hs_count;
    int cyc = 0;
    int sof_cyc;
    int eof_cyc;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            if (en[k] && src_q[k].size() > 0) begin
                s_tvalid[k]         = 1'b1;
                s_tdata[k*32 +: 32] = src_q[k][0].data;
                s_tlast[k]          = src_q[k][0].last;
            end else begin
                s_tvalid[k]         = 1'b0;
                s_tdata[k*32 +: 32] = '0;
                s_tlast[k]          = 1'b0;
            end
        end
    endtask

    // Source side: words leave their queue after a handshake; m_tready follows the chosen mode.
    initial begin
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++)
                if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            m_tready = (mt_mode == 0) ? 1'b1 : 1'($urandom & 1);
            refresh();
        end
    end

    always @(posedge clk) cyc++;

    item_t mon_it;
    int    exp_tag;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (exp_q.size() > 0)
                    check("s_tready_pass", s_tready, m_tready ? (N'(1) << exp_q[0].src) : '0);
            end else begin
                check("arb_quiet", {m_tvalid, s_tready}, '0);
            end
            if (m_tvalid && m_tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    fail("unexpected_word", $sformatf("got=%0h expected=none", m_tdata));
                end else begin
                    mon_it = exp_q.pop_front();
                    check("m_tdata", m_tdata, mon_it.data);
                    check("m_tlast", m_tlast, mon_it.last);
                    if (mon_it.first) begin
                        sof_cyc = cyc;
                        if (gap_chk != 0 && gap_armed != 0) check("frame_gap", cyc - eof_cyc, 2);
                    end
                    if (mon_it.last) begin
                        eof_cyc   = cyc;
                        gap_armed = 1;
                        frames_done++;
                    end
                end
            end
            if (pix_tvalid && pix_tready && pix_tlast && tag_q.size() > 0) begin
                exp_tag = tag_q.pop_front();
                check("out_src_vld", out_src_vld, 1);
                check("out_src", out_src, exp_tag);
            end
        end
    end

    // Builds frames per source and predicts frame order: next pending source after the last one, cyclically.
    task automatic load_phase(input int n0, input int n1, input int n2, input int n3, input int fixed_len);
        int    rem [N];
        int    ptr;
        int    nfr;
        int    len;
        item_t it;
        rem = '{n0, n1, n2, n3};
        nfr = 0;
        for (int k = 0; k < N; k++) begin
            nfr += rem[k];
            for (int f = 0; f < rem[k]; f++) begin
                len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
                for (int w = 0; w < len; w++) begin
                    it.src   = k;
                    it.data  = $urandom;
                    it.first = (w == 0);
                    it.last  = (w == len - 1);
                    src_q[k].push_back(it);
                    stage[k].push_back(it);
                end
            end
        end
        ptr = rr_last;
        for (int f = 0; f < nfr; f++) begin
            do begin
                ptr = (ptr + 1) % N;
            end while (rem[ptr] == 0);
            rem[ptr]--;
            tag_q.push_back(ptr);
            do begin
                it = stage[ptr].pop_front();
                exp_q.push_back(it);
            end while (!it.last);
        end
        rr_last = ptr;
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        pix_tvalid = 1'b0;
        pix_tready = 1'b0;
        pix_tlast  = 1'b0;
        if (auto_pop != 0 && frames_done > pops_done) begin
            pix_tvalid = 1'b1;
            pix_tready = 1'b1;
            pix_tlast  = 1'b1;
            pops_done++;
        end
    endtask

    task automatic pop_now(input bit counted);
        pix_tvalid = 1'b1;
        pix_tready = 1'b1;
        pix_tlast  = 1'b1;
        if (counted) pops_done++;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || (auto_pop != 0 && pops_done < frames_done)) && n < budget) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) fail(name, $sformatf("timeout with %0d words outstanding, expected 0", exp_q.size()));
    endtask

    initial begin
        int t0;
        int base;
        int n;
        rst = 1'b1; en = '0; mt_mode = 0; m_tready = 1'b1;
        pix_tvalid = 1'b0; pix_tready = 1'b0; pix_tlast = 1'b0;
        auto_pop = 0; gap_chk = 0; gap_armed = 0;
        frames_done = 0; pops_done = 0; hs_count = 0;
        sof_cyc = 0; eof_cyc = 0; rr_last = N - 1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_src_vld", out_src_vld, 0);
        check("rst_out_src", out_src, 0);
        check("rst_err_orphan", err_orphan, 0);

        // All sources valid out of reset: order 0,1,2,3,0 with one idle cycle per frame.
        en = '1; auto_pop = 1; gap_chk = 1; gap_armed = 0;
        load_phase(2, 1, 1, 1, 0);
        tick();
        rst = 1'b0;
        wait_drain("t2_drain", 300);
        gap_chk = 0;

        // Single 3-word frame on source 2.
        auto_pop = 0;
        tick();
        t0 = cyc;
        load_phase(0, 0, 1, 0, 3);
        wait_drain("t1_drain", 50);
        check("t1_grant_latency", sof_cyc, t0 + 1);
        check("t1_out_src", out_src, 2);
        check("t1_out_src_vld", out_src_vld, 1);
        tick(); pop_now(1'b1); @(negedge clk);
        tick(); @(negedge clk);
        check("t1_fifo_empty", out_src_vld, 0);

        // 40-word frame under random backpressure.
        mt_mode = 1; auto_pop = 1;
        tick();
        load_phase(0, 1, 0, 0, 40);
        wait_drain("t3_drain", 600);
        mt_mode = 0;

        // Tag FIFO full: fifth frame waits until one pixel frame retires.
        auto_pop = 0;
        tick();
        load_phase(2, 1, 1, 1, 2);
        base = frames_done; n = 0;
        while (frames_done - base < 4 && n < 200) begin tick(); @(negedge clk); n++; end
        if (frames_done - base < 4) fail("t4_fill", $sformatf("frames=%0d expected=4", frames_done - base));
        repeat (3) begin tick(); @(negedge clk); end
        check("t4_busy_held", busy, 0);
        check("t4_s_tready_held", s_tready, 0);
        check("t4_out_src_vld", out_src_vld, 1);
        tick(); pop_now(1'b1); @(negedge clk);
        tick(); @(negedge clk);
        check("t4_arb_cycle", busy, 0);
        tick(); @(negedge clk);
        check("t4_grant_after_pop", busy, 1);
        auto_pop = 1;
        wait_drain("t4_drain", 200);

        // Push and pop in the same cycle at count 1, then an orphan pop.
        auto_pop = 0;
        tick();
        load_phase(1, 0, 0, 0, 2);
        wait_drain("t5_first", 50);
        tick(); pop_now(1'b1); load_phase(0, 0, 0, 1, 2); @(negedge clk);
        tick(); @(negedge clk);
        check("t5_head_advanced", out_src, 3);
        check("t5_count_one", out_src_vld, 1);
        wait_drain("t5_second", 50);
        tick(); pop_now(1'b1); @(negedge clk);
        tick(); @(negedge clk);
        check("t5_empty", out_src_vld, 0);
        check("t5_no_orphan_yet", err_orphan, 0);
        tick(); pop_now(1'b0); @(negedge clk);
        tick(); @(negedge clk);
        check("t5_orphan_set", err_orphan, 1);
        repeat (3) begin tick(); @(negedge clk); end
        check("t5_orphan_held", err_orphan, 1);

        // Reset in the middle of a 10-word frame from source 1.
        tick();
        load_phase(0, 1, 0, 0, 10);
        base = hs_count; n = 0;
        while (hs_count - base < 5 && n < 50) begin tick(); @(negedge clk); n++; end
        if (hs_count - base < 5) fail("t6_words", $sformatf("words=%0d expected=5", hs_count - base));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en  = '0;
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            stage[k].delete();
        end
        exp_q.delete();
        tag_q.delete();
        pops_done = frames_done;
        rr_last   = N - 1;
        refresh();
        @(negedge clk);
        check("t6_s_tready", s_tready, 0);
        check("t6_m_tvalid", m_tvalid, 0);
        check("t6_busy", busy, 0);
        check("t6_out_src_vld", out_src_vld, 0);
        check("t6_err_cleared", err_orphan, 0);
        en = '1; auto_pop = 1;
        tick();
        load_phase(0, 1, 0, 1, 3);
        wait_drain("t6_drain", 100);

        // Random mixes of frames under random backpressure.
        mt_mode = 1;
        repeat (4) begin
            tick();
            load_phase($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0);
            wait_drain("rand_drain", 500);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
